// File: rtl/ex_hazard_ctrl.sv
// Execute-stage hazard controller: operand forwarding, load-use stall, branch flush,
// multi-cycle MUL/DIV sequencing with watchdog, and a saturating stall-cycle counter.
module ex_hazard_ctrl #(
    parameter int REG_ADDR_WIDTH  = 5,
    parameter int STALL_CNT_WIDTH = 32,
    parameter int MDU_MAX_CYCLES  = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [REG_ADDR_WIDTH-1:0]  rs1_addr_d_i,
    input  logic [REG_ADDR_WIDTH-1:0]  rs2_addr_d_i,
    input  logic [REG_ADDR_WIDTH-1:0]  rs1_addr_e_i,
    input  logic [REG_ADDR_WIDTH-1:0]  rs2_addr_e_i,
    input  logic [REG_ADDR_WIDTH-1:0]  rd_addr_e_i,
    input  logic                       result_src_e0_i,
    input  logic [REG_ADDR_WIDTH-1:0]  rd_addr_m_i,
    input  logic                       reg_write_m_i,
    input  logic [REG_ADDR_WIDTH-1:0]  rd_addr_w_i,
    input  logic                       reg_write_w_i,
    input  logic                       pc_src_e_i,
    input  logic                       mdu_op_e_i,
    input  logic                       mdu_done_i,
    output logic [1:0]                 forward_a_e_o,
    output logic [1:0]                 forward_b_e_o,
    output logic                       stall_f_o,
    output logic                       stall_d_o,
    output logic                       stall_e_o,
    output logic                       flush_d_o,
    output logic                       flush_e_o,
    output logic                       flush_m_o,
    output logic                       mdu_start_o,
    output logic                       mdu_timeout_o,
    output logic [STALL_CNT_WIDTH-1:0] stall_cnt_o
);

    localparam int WD_W = (MDU_MAX_CYCLES > 2) ? $clog2(MDU_MAX_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(MDU_MAX_CYCLES - 1);

    typedef enum logic {IDLE, MDU_BUSY} state_e;

    state_e                     state_q, state_d;
    logic [WD_W-1:0]            wd_q, wd_d;
    logic                       timeout_q, timeout_d;
    logic [STALL_CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                       start_c;
    logic                       lwstall;

    // MEM result is younger than WB, so it wins when both match.
    function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_WIDTH-1:0] rs);
        if (reg_write_m_i && rd_addr_m_i != '0 && rd_addr_m_i == rs)      return 2'b10;
        else if (reg_write_w_i && rd_addr_w_i != '0 && rd_addr_w_i == rs) return 2'b01;
        else                                                              return 2'b00;
    endfunction

    assign forward_a_e_o = fwd_sel(rs1_addr_e_i);
    assign forward_b_e_o = fwd_sel(rs2_addr_e_i);

    assign lwstall = result_src_e0_i && rd_addr_e_i != '0 &&
                     (rd_addr_e_i == rs1_addr_d_i || rd_addr_e_i == rs2_addr_d_i);

    always_comb begin
        state_d   = state_q;
        wd_d      = wd_q;
        timeout_d = timeout_q;
        start_c   = 1'b0;
        stall_f_o = 1'b0;
        stall_d_o = 1'b0;
        stall_e_o = 1'b0;
        flush_d_o = 1'b0;
        flush_e_o = 1'b0;
        flush_m_o = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (mdu_op_e_i && !pc_src_e_i) begin
                    start_c   = 1'b1;
                    stall_f_o = 1'b1;
                    stall_d_o = 1'b1;
                    stall_e_o = 1'b1;
                    flush_m_o = 1'b1;
                    state_d   = MDU_BUSY;
                end else begin
                    // A taken branch flushes the wrong-path ID instruction instead of stalling it.
                    stall_f_o = lwstall && !pc_src_e_i;
                    stall_d_o = lwstall && !pc_src_e_i;
                    flush_e_o = lwstall || pc_src_e_i;
                    flush_d_o = pc_src_e_i;
                end
            end
            MDU_BUSY: begin
                if (mdu_done_i) begin
                    state_d = IDLE;
                    wd_d    = '0;
                end else begin
                    stall_f_o = 1'b1;
                    stall_d_o = 1'b1;
                    stall_e_o = 1'b1;
                    flush_m_o = 1'b1;
                    wd_d      = wd_q + 1'b1;
                    if (wd_q == WD_LAST) begin
                        timeout_d = 1'b1;
                        flush_e_o = 1'b1;
                        state_d   = IDLE;
                        wd_d      = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        cnt_d = (stall_f_o && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            wd_q      <= '0;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
            cnt_q     <= cnt_d;
        end
    end

    assign mdu_start_o   = start_c && !rst;
    assign mdu_timeout_o = timeout_q;
    assign stall_cnt_o   = cnt_q;

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Bench for ex_hazard_ctrl: a default-parameter instance checked cycle-by-cycle against a
// queued reference model, plus a narrow-counter / short-watchdog instance checked at corner points.
module tb_ex_hazard_ctrl;

    localparam int MAXA = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic rse0, wm, ww, pc, mop, done;

    logic [1:0] fa_a, fb_a, fa_b, fb_b;
    logic sf_a, sd_a, se_a, fd_a, fe_a, fm_a, st_a, to_a;
    logic sf_b, sd_b, se_b, fd_b, fe_b, fm_b, st_b, to_b;
    logic [31:0] cnt_a;
    logic [3:0]  cnt_b;

    always #5 clk = ~clk;

    ex_hazard_ctrl u_a (
        .clk(clk), .rst(rst),
        .rs1_addr_d_i(rs1d), .rs2_addr_d_i(rs2d), .rs1_addr_e_i(rs1e), .rs2_addr_e_i(rs2e),
        .rd_addr_e_i(rde), .result_src_e0_i(rse0), .rd_addr_m_i(rdm), .reg_write_m_i(wm),
        .rd_addr_w_i(rdw), .reg_write_w_i(ww), .pc_src_e_i(pc), .mdu_op_e_i(mop), .mdu_done_i(done),
        .forward_a_e_o(fa_a), .forward_b_e_o(fb_a), .stall_f_o(sf_a), .stall_d_o(sd_a),
        .stall_e_o(se_a), .flush_d_o(fd_a), .flush_e_o(fe_a), .flush_m_o(fm_a),
        .mdu_start_o(st_a), .mdu_timeout_o(to_a), .stall_cnt_o(cnt_a)
    );

    ex_hazard_ctrl #(.STALL_CNT_WIDTH(4), .MDU_MAX_CYCLES(8)) u_b (
        .clk(clk), .rst(rst),
        .rs1_addr_d_i(rs1d), .rs2_addr_d_i(rs2d), .rs1_addr_e_i(rs1e), .rs2_addr_e_i(rs2e),
        .rd_addr_e_i(rde), .result_src_e0_i(rse0), .rd_addr_m_i(rdm), .reg_write_m_i(wm),
        .rd_addr_w_i(rdw), .reg_write_w_i(ww), .pc_src_e_i(pc), .mdu_op_e_i(mop), .mdu_done_i(done),
        .forward_a_e_o(fa_b), .forward_b_e_o(fb_b), .stall_f_o(sf_b), .stall_d_o(sd_b),
        .stall_e_o(se_b), .flush_d_o(fd_b), .flush_e_o(fe_b), .flush_m_o(fm_b),
        .mdu_start_o(st_b), .mdu_timeout_o(to_b), .stall_cnt_o(cnt_b)
    );

    typedef struct packed {
        logic [1:0]  fa, fb;
        logic        sf, sd, se, fd, fe, fm, st, to;
        logic [31:0] cnt;
    } obs_t;

    obs_t sbq[$];
    obs_t last_a;
    logic lb_sf, lb_fe, lb_st, lb_to;
    logic [3:0] lb_cnt;
    int n_tests = 0, n_fail = 0, cyc = 0;

    // reference model state for u_a
    bit m_busy, m_to;
    int m_wd;
    longint m_cnt;

    function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
        if (wm && rdm != 0 && rdm == rs) return 2'b10;
        if (ww && rdw != 0 && rdw == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic idle_inputs();
        rs1d = 0; rs2d = 0; rs1e = 0; rs2e = 0; rde = 0; rdm = 0; rdw = 0;
        rse0 = 0; wm = 0; ww = 0; pc = 0; mop = 0; done = 0;
    endtask

    task automatic model_clear();
        m_busy = 0; m_to = 0; m_wd = 0; m_cnt = 0;
        sbq.delete();
    endtask

    // One clock: predict, queue, sample at negedge, compare, advance the model.
    task automatic step();
        obs_t e, act, ex;
        bit lw;
        e = '0;
        lw = rse0 && rde != 0 && (rde == rs1d || rde == rs2d);
        e.fa = ref_fwd(rs1e);
        e.fb = ref_fwd(rs2e);
        e.to = m_to;
        e.cnt = m_cnt[31:0];
        if (!m_busy) begin
            if (mop && !pc) begin
                e.st = 1; e.sf = 1; e.sd = 1; e.se = 1; e.fm = 1;
            end else begin
                e.sf = lw && !pc; e.sd = lw && !pc; e.fe = lw || pc; e.fd = pc;
            end
        end else if (!done) begin
            e.sf = 1; e.sd = 1; e.se = 1; e.fm = 1;
            e.fe = (m_wd == MAXA - 1);
        end
        sbq.push_back(e);
        @(negedge clk);
        act = {fa_a, fb_a, sf_a, sd_a, se_a, fd_a, fe_a, fm_a, st_a, to_a, cnt_a};
        last_a = act;
        lb_sf = sf_b; lb_fe = fe_b; lb_st = st_b; lb_to = to_b; lb_cnt = cnt_b;
        ex = sbq.pop_front();
        n_tests++;
        if (act !== ex) begin
            n_fail++;
            $display("FAIL scoreboard cyc=%0d actual=%h expected=%h", cyc, act, ex);
        end
        @(posedge clk);
        if (m_busy) begin
            if (done) begin m_busy = 0; m_wd = 0; end
            else if (m_wd == MAXA - 1) begin m_to = 1; m_busy = 0; m_wd = 0; end
            else m_wd++;
        end else if (e.st) m_busy = 1;
        if (e.sf && m_cnt != 64'hFFFF_FFFF) m_cnt++;
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;
        model_clear();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic test_reset();
        do_reset();
        chk("rst_outs_a", {sf_a, sd_a, se_a, fd_a, fe_a, fm_a, st_a, to_a}, 0);
        chk("rst_cnt_a", cnt_a, 0);
        chk("rst_outs_b", {sf_b, st_b, to_b, cnt_b}, 0);
        step();
    endtask

    task automatic test_forward();
        rs1e = 5; rdm = 5; wm = 1; rdw = 5; ww = 1;
        step(); chk("fwd_mem_prio", last_a.fa, 2);
        rdm = 0;
        step(); chk("fwd_x0_mem", last_a.fa, 1);
        rs2e = 9; rdm = 9; wm = 0; rdw = 9;
        step(); chk("fwd_b_wb", last_a.fb, 1);
        ww = 0;
        step(); chk("fwd_b_none", last_a.fb, 0);
        rdw = 0; ww = 1; rs2e = 0;
        step(); chk("fwd_x0_wb", last_a.fb, 0);
        idle_inputs();
    endtask

    task automatic test_lwstall();
        rse0 = 1; rde = 7; rs2d = 7;
        step();
        chk("lw_stall", {last_a.sf, last_a.sd, last_a.fe, last_a.fd}, 4'b1110);
        rse0 = 0;
        step();
        chk("lw_one_cycle", {last_a.sf, last_a.fe}, 0);
        rse0 = 1; pc = 1;
        step();
        chk("lw_branch", {last_a.sf, last_a.sd, last_a.fd, last_a.fe}, 4'b0011);
        rse0 = 0; mop = 1;
        step();
        chk("mdu_branch_nostart", {last_a.st, last_a.fd, last_a.fe}, 3'b011);
        pc = 0; mop = 0; rse0 = 1; rde = 0; rs1d = 0;
        step();
        chk("lw_rd0", last_a.sf, 0);
        idle_inputs();
    endtask

    task automatic test_mdu();
        int starts = 0, stalls = 0;
        do_reset();
        mop = 1;
        for (int i = 0; i < 11; i++) begin
            step(); starts += last_a.st; stalls += last_a.sf;
        end
        done = 1;
        step(); starts += last_a.st; stalls += last_a.sf;
        chk("mdu_release", {last_a.sf, last_a.sd, last_a.se, last_a.fm}, 0);
        done = 0; mop = 0;
        step(); starts += last_a.st;
        chk("mdu_starts", starts, 1);
        chk("mdu_stalls", stalls, 11);
        chk("mdu_cnt", last_a.cnt, 11);
    endtask

    task automatic test_timeout();
        do_reset();
        mop = 1;
        step();
        chk("to_start_b", lb_st, 1);
        mop = 0;
        for (int i = 1; i <= 8; i++) begin
            step();
            chk("to_flush_e_b", lb_fe, (i == 8));
            chk("to_not_yet_b", lb_to, 0);
        end
        step();
        chk("to_set_b", {lb_to, lb_sf}, 2'b10);
        done = 1;
        step();
        chk("to_done_idle_b", {lb_to, lb_sf}, 2'b10);
        done = 0; mop = 1;
        step();
        chk("to_sticky_b", {lb_st, lb_to}, 2'b11);
        mop = 0; done = 1;
        step();
        done = 0;
        step();
    endtask

    task automatic test_reset_mid();
        int starts = 0;
        do_reset();
        mop = 1;
        step();
        mop = 0;
        repeat (3) step();
        #2;
        rst = 1;
        #1;
        chk("amid_outs_a", {sf_a, sd_a, se_a, fm_a, st_a}, 0);
        chk("amid_cnt_a", cnt_a, 0);
        chk("amid_b", {sf_b, to_b, cnt_b}, 0);
        @(negedge clk);
        rst = 0;
        model_clear();
        @(posedge clk);
        #1;
        repeat (3) begin step(); starts += last_a.st + lb_st; end
        chk("amid_nostart", starts, 0);
    endtask

    task automatic test_saturate();
        do_reset();
        rse0 = 1; rde = 3; rs1d = 3;
        for (int i = 0; i < 20; i++) begin
            step();
            if (i == 15) chk("sat_reach_b", lb_cnt, 15);
        end
        chk("sat_hold_b", lb_cnt, 15);
        idle_inputs();
        step();
        chk("sat_cnt_a", last_a.cnt, 20);
        chk("sat_final_b", cnt_b, 15);
    endtask

    initial begin
        idle_inputs();
        model_clear();
        test_reset();
        test_forward();
        test_lwstall();
        test_mdu();
        test_timeout();
        test_reset_mid();
        test_saturate();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
